fetch_byte_queue: RTL and testbench
===================================

# fetch_byte_queue

Fetch-side block between the byte-wide instruction memory (`rom_512x8`) and the IF/ID pipeline register. It walks a fetch PC and reads one byte per cycle, assembling big-endian 32-bit instructions. Completed words and their PCs go into a small FIFO, and the IF/ID register consumes them under its load-enable. A redirect (taken branch, call, jmpl, reset handler) flushes the queue and any partial word, then restarts fetch at the target.

## Interface
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `AW`, 8: instruction-memory byte-address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  flush queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `mem_addr`  out  AW  byte address to instruction memory.
- `mem_data`  in  8  byte at `mem_addr`, combinational, same cycle.
- `if_ready`  in  1  IF/ID load-enable; pops the head when `if_valid`.
- `if_valid`  out  1  queue non-empty.
- `if_instr`  out  32  head instruction; 0 when empty.
- `if_pc`  out  32  PC of head instruction; 0 when empty.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.

## Operation
- State: `fetch_pc[31:0]`, `byte_cnt[1:0]`, `word_sr[31:0]`, FSM {FILL, WAIT}, FIFO of {instr, pc}.
- `mem_addr` = (`fetch_pc` + `byte_cnt`) mod 2^AW.
- FILL, byte_cnt < 3:
  - shift `mem_data` into `word_sr`; byte 0 lands in [31:24], byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0];
  - `byte_cnt`++.
- FILL, byte_cnt = 3, space available (not full, or full with a pop this cycle):
  - push {`word_sr`[31:8], `mem_data`} with pc = `fetch_pc`;
  - `fetch_pc` += 4, wrapping mod 2^32;
  - `byte_cnt` = 0; stay in FILL.
- FILL, byte_cnt = 3, no space:
  - latch `mem_data` into `word_sr`[7:0]; go to WAIT.
- WAIT:
  - no memory reads; `mem_addr` holds `fetch_pc`+3.
  - When space is available (same rule as FILL), push `word_sr` with pc = `fetch_pc`, `fetch_pc` += 4, `byte_cnt` = 0, go to FILL.
- Pop: `if_valid` && `if_ready` removes the head.
  - Simultaneous push and pop leaves `occupancy` unchanged, including when full.
  - `if_ready` while empty is ignored.
- Redirect has top priority. In the same cycle it:
  - empties the FIFO; the pop and push for that cycle are discarded;
  - sets `fetch_pc` = {`redirect_pc`[31:2], 2'b00}, `byte_cnt` = 0, `word_sr` = 0, FSM = FILL.

## Timing
- Reset (`clr` low, async): `fetch_pc` = 0, `byte_cnt` = 0, `word_sr` = 0, FSM = FILL, FIFO empty. Outputs: `mem_addr` = 0, `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `occupancy` = 0.
- Reset asserted mid-word drops the partial word; no push occurs.
- Fetch latency: the first instruction becomes visible after the 4th rising edge following reset release or a redirect edge.
- Sustained throughput is one instruction per 4 cycles.
- `if_instr`, `if_pc`, `if_valid` are registered FIFO-head values and change only on clock edges or async reset.
- A word pushed into an empty FIFO is visible one edge after the push.
- In WAIT, a pop frees space in the same cycle, so the pending word is pushed on that edge.
- Full FIFO with `if_ready` held low: no memory advance beyond byte 3; `occupancy` = DEPTH.

## Structure
- Shared package `sparc_fetch_pkg` holds:
  - FSM enum {FILL, WAIT};
  - `BYTE_LAST` = 2'd3;
  - `INSTR_BYTES` = 4;
  - queue entry struct {instr[31:0], pc[31:0]}.
- One sub-module, `instr_queue`:
  - circular FIFO parameterised by DEPTH;
  - ports: push, pop, flush, entry in, head out, full, empty, count;
  - wrap-around read/write pointers with one extra bit for full/empty.
- Top level holds the FSM, byte assembler and `fetch_pc` counter.

## Test plan
- Reset then preload ROM bytes 0x00..0x07 = 8C 00 00 01 82 10 20 05, `if_ready` = 1:
  - `if_instr` = 8C000001 / `if_pc` = 0 after edge 4;
  - then 82102005 / `if_pc` = 4 after edge 8.
- `if_ready` = 0 for 30 cycles, DEPTH = 4:
  - `occupancy` saturates at 4, FSM in WAIT, `mem_addr` = 19;
  - raise `if_ready`: 5th word (pc 16) is pushed on that edge.
- `redirect_pc` = 0x26 while queue holds 3 words and `byte_cnt` = 2:
  - next edge `if_valid` = 0 and `mem_addr` = 0x24;
  - first word reported with `if_pc` = 0x24.
- `fetch_pc` = 0xFC with AW = 8:
  - `mem_addr` sequence FC, FD, FE, FF; next word reads from 00;
  - `if_pc` = 0x100 for the second word.
- Redirect asserted together with pop and push while full:
  - queue empty next cycle; `occupancy` = 0; no stale word appears.
- Async `clr` low mid-cycle during WAIT:
  - all outputs 0 immediately;
  - after release, fetch restarts at PC 0.

Source files
------------

// File: rtl/sparc_fetch_pkg.sv
// sparc_fetch_pkg: shared types and constants for the byte-serial instruction fetch path
package sparc_fetch_pkg;
    typedef enum logic {FILL, WAIT} state_t;
    localparam logic [1:0] BYTE_LAST   = 2'd3;
    localparam int         INSTR_BYTES = 4;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;
endpackage

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of {instr, pc} entries
//   push_i/pop_i request a write/read; pop is ignored when empty, push needs space or a same-cycle pop
//   flush_i empties the queue and discards that cycle's push and pop
//   head_o is the oldest entry (0 when empty); full_o, empty_o, count_o report fill level
module instr_queue
    import sparc_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  entry_t      entry_i,
    output entry_t      head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [PW:0] count_o
);
    logic [PW:0] wr_q, wr_d, rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    logic        do_push, do_pop;
    assign count_o = wr_q - rd_q;
    assign empty_o = wr_q == rd_q;
    // count never exceeds DEPTH, so its top bit alone marks full
    assign full_o  = count_o[PW];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];
    always_comb begin
        wr_d = flush_i ? '0 : wr_q + {{PW{1'b0}}, do_push};
        rd_d = flush_i ? '0 : rd_q + {{PW{1'b0}}, do_pop};
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q[PW-1:0]] <= entry_i;
    end
endmodule

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: byte-serial instruction fetch assembling big-endian words into a queue
//   clk, clr (async active-low)
//   redirect/redirect_pc: flush and restart fetch at the word-aligned target
//   mem_addr/mem_data: byte read port to instruction memory (combinational data)
//   if_ready pops the head; if_valid/if_instr/if_pc present it; occupancy = entries held
module fetch_byte_queue
    import sparc_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [AW-1:0]            mem_addr,
    input  logic [7:0]               mem_data,
    input  logic                     if_ready,
    output logic                     if_valid,
    output logic [31:0]              if_instr,
    output logic [31:0]              if_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, word_sr_q, word_sr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        push, full, empty, space;
    entry_t      push_entry, head;
    assign mem_addr = AW'(fetch_pc_q + {30'd0, byte_cnt_q});
    // a pop in the same cycle frees a slot for the push
    assign space    = !full || (if_valid && if_ready);
    assign if_valid = !empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_cnt_d = byte_cnt_q;
        word_sr_d  = word_sr_q;
        push       = 1'b0;
        push_entry = '{instr: word_sr_q, pc: fetch_pc_q};
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'd3;
            byte_cnt_d = '0;
            word_sr_d  = '0;
            state_d    = FILL;
        end else if (state_q == WAIT) begin
            if (space) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
                byte_cnt_d = '0;
                state_d    = FILL;
            end
        end else begin
            // byte n lands big-endian; the last byte completes the word in [7:0]
            word_sr_d[8*(BYTE_LAST - byte_cnt_q) +: 8] = mem_data;
            if (byte_cnt_q != BYTE_LAST) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end else if (space) begin
                push             = 1'b1;
                push_entry.instr = word_sr_d;
                fetch_pc_d       = fetch_pc_q + 32'(INSTR_BYTES);
                byte_cnt_d       = '0;
            end else begin
                state_d = WAIT;
            end
        end
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= FILL;
            fetch_pc_q <= '0;
            byte_cnt_q <= '0;
            word_sr_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_cnt_q <= byte_cnt_d;
            word_sr_q  <= word_sr_d;
        end
    end
    instr_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .clr     (clr),
        .push_i  (push),
        .pop_i   (if_ready),
        .flush_i (redirect),
        .entry_i (push_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );
endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb_fetch_byte_queue: directed bench with a ROM model and a scoreboard of expected {instr, pc}
module tb_fetch_byte_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    logic                   clk = 1'b0;
    logic                   clr = 1'b0;
    logic                   redirect = 1'b0;
    logic [31:0]            redirect_pc = '0;
    logic                   if_ready = 1'b0;
    logic [AW-1:0]          mem_addr;
    logic [7:0]             mem_data;
    logic                   if_valid;
    logic [31:0]            if_instr, if_pc;
    logic [$clog2(DEPTH):0] occupancy;
    logic [7:0]             rom [256];
    logic [63:0]            sb [$];
    int                     n_assert = 0;
    int                     n_fail = 0;

    assign mem_data = rom[mem_addr];
    always #5 clk = ~clk;

    fetch_byte_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .clr         (clr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .if_ready    (if_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .occupancy   (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [7:0] a;
        a = pc[7:0];
        return {rom[a], rom[8'(a + 8'd1)], rom[8'(a + 8'd2)], rom[8'(a + 8'd3)]};
    endfunction

    task automatic sb_load(input logic [31:0] pc);
        sb.delete();
        for (int k = 0; k < 24; k++) sb.push_back({word_at(pc + 32'(4 * k)), pc + 32'(4 * k)});
    endtask

    // check the head at the pop point, then advance one edge and settle
    task automatic tick();
        @(negedge clk);
        if (if_valid && if_ready && !redirect) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else chk("head", {if_instr, if_pc}, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        sb_load(pc & ~32'd3);
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11);
        rom[0] = 8'h8C; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h01;
        rom[4] = 8'h82; rom[5] = 8'h10; rom[6] = 8'h20; rom[7] = 8'h05;
        @(posedge clk);
        #1;
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_instr", 64'(if_instr), 64'd0);
        chk("rst_pc", 64'(if_pc), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        clr = 1'b1;
        sb_load(0);
        if_ready = 1'b1;
        ticks(4);
        chk("lat_valid", 64'(if_valid), 64'd1);
        chk("lat_instr0", 64'(if_instr), 64'h8C000001);
        chk("lat_pc0", 64'(if_pc), 64'd0);
        ticks(4);
        chk("lat_instr1", 64'(if_instr), 64'h82102005);
        chk("lat_pc1", 64'(if_pc), 64'd4);
        // backpressure to full, then release
        if_ready = 1'b0;
        do_redirect(0);
        ticks(30);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_mem_addr", 64'(mem_addr), 64'd19);
        chk("full_head_pc", 64'(if_pc), 64'd0);
        tick();
        chk("wait_hold_addr", 64'(mem_addr), 64'd19);
        if_ready = 1'b1;
        tick();
        chk("release_occ", 64'(occupancy), 64'd4);
        chk("release_addr", 64'(mem_addr), 64'd20);
        chk("release_head_pc", 64'(if_pc), 64'd4);
        ticks(10);
        // redirect with a partially filled word and three queued words
        if_ready = 1'b0;
        do_redirect(0);
        ticks(14);
        chk("pre_redir_occ", 64'(occupancy), 64'd3);
        chk("pre_redir_addr", 64'(mem_addr), 64'd14);
        do_redirect(32'h26);
        chk("redir_valid", 64'(if_valid), 64'd0);
        chk("redir_addr", 64'(mem_addr), 64'h24);
        chk("redir_occ", 64'(occupancy), 64'd0);
        if_ready = 1'b1;
        ticks(4);
        chk("redir_first_valid", 64'(if_valid), 64'd1);
        chk("redir_first_pc", 64'(if_pc), 64'h24);
        ticks(4);
        // address wrap at the top of the AW space
        do_redirect(32'hFC);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", 64'(mem_addr), 64'(8'(8'hFC + k)));
            tick();
        end
        chk("wrap_addr_next", 64'(mem_addr), 64'd0);
        chk("wrap_pc_first", 64'(if_pc), 64'hFC);
        ticks(4);
        chk("wrap_pc_second", 64'(if_pc), 64'h100);
        chk("wrap_instr_second", 64'(if_instr), 64'h8C000001);
        ticks(2);
        // redirect coinciding with pop and pending push while full
        if_ready = 1'b0;
        do_redirect(0);
        ticks(30);
        chk("rpp_full", 64'(occupancy), 64'd4);
        if_ready = 1'b1;
        do_redirect(32'h40);
        chk("rpp_occ", 64'(occupancy), 64'd0);
        chk("rpp_valid", 64'(if_valid), 64'd0);
        chk("rpp_instr", 64'(if_instr), 64'd0);
        chk("rpp_pc", 64'(if_pc), 64'd0);
        ticks(3);
        chk("rpp_no_stale", 64'(if_valid), 64'd0);
        tick();
        chk("rpp_first_pc", 64'(if_pc), 64'h40);
        chk("rpp_first_valid", 64'(if_valid), 64'd1);
        ticks(2);
        // asynchronous reset while waiting for space
        if_ready = 1'b0;
        do_redirect(0);
        ticks(30);
        #2;
        clr = 1'b0;
        #1;
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_valid", 64'(if_valid), 64'd0);
        chk("arst_instr", 64'(if_instr), 64'd0);
        chk("arst_pc", 64'(if_pc), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        sb_load(0);
        if_ready = 1'b1;
        ticks(4);
        chk("arst_restart_valid", 64'(if_valid), 64'd1);
        chk("arst_restart_pc", 64'(if_pc), 64'd0);
        chk("arst_restart_instr", 64'(if_instr), 64'h8C000001);
        ticks(8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
